// File: rtl/invntt_gs_addsub.sv
// rtl/invntt_gs_addsub.sv - Gentleman-Sande add/sub stage feeding the inverse-NTT halving unit
// Optional build macro: INVNTT_RANGE_CHK_EN (sticky o_err on out-of-range accepted inputs).
module invntt_gs_addsub #(
  parameter int WID   = 12,
  parameter int Q     = 3329,
  parameter int NPAIR = 128,
  parameter int CW    = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_vld,
  output logic           o_rdy,
  input  logic [WID-1:0] i_a,
  input  logic [WID-1:0] i_b,
  output logic           o_vld,
  output logic [WID-1:0] o_sum,
  output logic [WID-1:0] o_diff,
  output logic           o_half_vld,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [WID:0] QW   = Q[WID:0];
  localparam logic [CW-1:0] LAST = CW'(NPAIR - 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           vld_d1;
  logic           accept;
  logic           last_half;
  logic [WID:0]   s_full, d_full;
  logic [WID-1:0] sum_w, diff_w;

  assign accept = i_vld & o_rdy;

  assign s_full = {1'b0, i_a} + {1'b0, i_b};
  assign d_full = {1'b0, i_a} - {1'b0, i_b};
  assign sum_w  = WID'((s_full >= QW) ? s_full - QW : s_full);
  // MSB of the WID+1-bit difference is the borrow, i.e. a<b
  assign diff_w = WID'(d_full[WID] ? d_full + QW : d_full);

  // Last halved result: nothing younger is left in the 2-stage tail
  assign last_half = o_half_vld & ~vld_d1 & ~o_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_rdy     = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = RUN;
      end
      RUN: begin
        o_rdy  = 1'b1;
        o_busy = 1'b1;
        if (accept && cnt == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (last_half) begin
          o_done    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == IDLE && i_start) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_vld      <= 1'b0;
      o_sum      <= '0;
      o_diff     <= '0;
      vld_d1     <= 1'b0;
      o_half_vld <= 1'b0;
    end else begin
      o_vld      <= accept;
      vld_d1     <= o_vld;
      o_half_vld <= vld_d1;
      if (accept) begin
        o_sum  <= sum_w;
        o_diff <= diff_w;
      end
    end
  end

`ifdef INVNTT_RANGE_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_err <= 1'b0;
    end else if (accept && (({1'b0, i_a} >= QW) || ({1'b0, i_b} >= QW))) begin
      o_err <= 1'b1;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule
